tree_branch_stage: RTL and testbench

- One internal decision-tree evaluation stage, instantiated as `internal_branch_stage` in a 2-D grid.
- A sample and a current node index arrive by valid/ready handshake. The stage fetches the node's descriptor (feature select, threshold) from the node memory and compares the selected sample feature against the threshold.
- It emits the child node index downward (next tree level) and forwards the sample rightward (next stage in the same level).
- Samples come from `sample_feeder` through a chain of `sample_pipeline_node` taps.

---
 rtl/tree_pkg.sv | 20 ++
 rtl/branch_compare.sv | 33 +++
 rtl/tree_branch_stage.sv | 114 +++++++++++
 tb/tb_tree_branch_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared types and default widths for the decision-tree branch stage.
// Imported by the stage, its comparator and the bench.
package tree_pkg;

    localparam int TREE_IDX_W    = 4;
    localparam int TREE_SAMPLE_W = 16;
    localparam int TREE_FEAT_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } state_t;

    typedef struct packed {
        logic [TREE_FEAT_W-1:0] featSel;
        logic [TREE_FEAT_W-1:0] threshold;
    } node_desc_t;

endpackage

// File: rtl/branch_compare.sv
// Combinational feature select, unsigned compare and child-index build.
// Receives only the low index bits; the top bit shifts out of the child.
module branch_compare #(
    parameter int IDX_W    = 4,
    parameter int SAMPLE_W = 16,
    parameter int FEAT_W   = 4
) (
    input  logic [IDX_W-2:0]    idx_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic [2*FEAT_W-1:0] desc_i,
    output logic [IDX_W-1:0]    child_o
);

    localparam int NF = SAMPLE_W / FEAT_W;

    logic [FEAT_W-1:0] sel;
    logic [FEAT_W-1:0] thr;
    logic [FEAT_W-1:0] feat;
    logic              gt;
    int                k;

    assign sel = desc_i[2*FEAT_W-1:FEAT_W];
    assign thr = desc_i[FEAT_W-1:0];

    always_comb begin
        k    = int'(sel) % NF;
        feat = sample_i[k*FEAT_W +: FEAT_W];
        gt   = feat > thr;
    end

    assign child_o = {idx_i, gt};

endmodule

// File: rtl/tree_branch_stage.sv
// Internal decision-tree stage: accept index+sample, fetch descriptor,
// emit child index downward and forward the sample rightward.
module tree_branch_stage
    import tree_pkg::*;
#(
    parameter int IDX_W    = TREE_IDX_W,
    parameter int SAMPLE_W = TREE_SAMPLE_W,
    parameter int FEAT_W   = TREE_FEAT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memRdy,
    input  logic                validIdxIn,
    input  logic                validSampIn,
    output logic                readyIn,
    output logic                validBottom,
    output logic                validRight,
    input  logic                readyBottom,
    input  logic                readyRight,
    input  logic [SAMPLE_W-1:0] sampleIn,
    output logic [SAMPLE_W-1:0] sampleOut,
    input  logic [IDX_W-1:0]    nodeIdxIn,
    output logic [IDX_W-1:0]    nodeIdxOut,
    input  logic [2*FEAT_W-1:0] nodeData,
    input  logic                nodeDataValid,
    output logic [IDX_W-1:0]    memAddr,
    output logic                memReq
);

    state_t              state_q;
    logic                readyIn_q;
    logic                vb_q, vb_d;
    logic                vr_q, vr_d;
    logic                memReq_q;
    logic [IDX_W-1:0]    idxOut_q;
    logic [SAMPLE_W-1:0] sampOut_q;
    logic [SAMPLE_W-1:0] samp_q;
    logic [IDX_W-1:0]    memAddr_q;
    logic [IDX_W-1:0]    child_d;

    // memAddr_q doubles as the latched node index.
    branch_compare #(
        .IDX_W    (IDX_W),
        .SAMPLE_W (SAMPLE_W),
        .FEAT_W   (FEAT_W)
    ) u_cmp (
        .idx_i    (memAddr_q[IDX_W-2:0]),
        .sample_i (samp_q),
        .desc_i   (nodeData),
        .child_o  (child_d)
    );

    always_comb begin
        vb_d = vb_q && !readyBottom;
        vr_d = vr_q && !readyRight;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            readyIn_q <= 1'b1;
            vb_q      <= 1'b0;
            vr_q      <= 1'b0;
            memReq_q  <= 1'b0;
            idxOut_q  <= '0;
            sampOut_q <= '0;
            samp_q    <= '0;
            memAddr_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (validIdxIn && validSampIn) begin
                        memAddr_q <= nodeIdxIn;
                        samp_q    <= sampleIn;
                        memReq_q  <= 1'b1;
                        readyIn_q <= 1'b0;
                        state_q   <= FETCH;
                    end
                end
                FETCH: begin
                    if (memRdy && nodeDataValid) begin
                        idxOut_q  <= child_d;
                        sampOut_q <= samp_q;
                        vb_q      <= 1'b1;
                        vr_q      <= 1'b1;
                        memReq_q  <= 1'b0;
                        state_q   <= OUT;
                    end
                end
                OUT: begin
                    vb_q <= vb_d;
                    vr_q <= vr_d;
                    if (!vb_d && !vr_d) begin
                        readyIn_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    readyIn_q <= 1'b1;
                end
            endcase
        end
    end

    assign readyIn     = readyIn_q;
    assign validBottom = vb_q;
    assign validRight  = vr_q;
    assign memReq      = memReq_q;
    assign memAddr     = memAddr_q;
    assign nodeIdxOut  = idxOut_q;
    assign sampleOut   = sampOut_q;

endmodule

// File: tb/tb_tree_branch_stage.sv
// Bench for tree_branch_stage: vector table plus output scoreboard.
module tb_tree_branch_stage;
    import tree_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memRdy = 1'b0;
    logic        validIdxIn = 1'b0;
    logic        validSampIn = 1'b0;
    logic        readyIn;
    logic        validBottom;
    logic        validRight;
    logic        readyBottom = 1'b1;
    logic        readyRight = 1'b1;
    logic [15:0] sampleIn = '0;
    logic [15:0] sampleOut;
    logic [3:0]  nodeIdxIn = '0;
    logic [3:0]  nodeIdxOut;
    logic [7:0]  nodeData = '0;
    logic        nodeDataValid = 1'b0;
    logic [3:0]  memAddr;
    logic        memReq;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0]  qb[$];
    logic [15:0] qr[$];

    always #5 clk = ~clk;

    tree_branch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .memRdy        (memRdy),
        .validIdxIn    (validIdxIn),
        .validSampIn   (validSampIn),
        .readyIn       (readyIn),
        .validBottom   (validBottom),
        .validRight    (validRight),
        .readyBottom   (readyBottom),
        .readyRight    (readyRight),
        .sampleIn      (sampleIn),
        .sampleOut     (sampleOut),
        .nodeIdxIn     (nodeIdxIn),
        .nodeIdxOut    (nodeIdxOut),
        .nodeData      (nodeData),
        .nodeDataValid (nodeDataValid),
        .memAddr       (memAddr),
        .memReq        (memReq)
    );

    typedef struct {
        logic [15:0] samp;
        logic [3:0]  idx;
        logic [3:0]  fs;
        logic [3:0]  thr;
        logic [3:0]  child;
        int          stall;
        int          bstall;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (validRight && readyRight) begin
                if (qr.size() == 0) chk("right_unexpected", 1, 0);
                else chk("sampleOut", sampleOut, qr.pop_front());
            end
            if (validBottom && readyBottom) begin
                if (qb.size() == 0) chk("bottom_unexpected", 1, 0);
                else chk("nodeIdxOut", nodeIdxOut, qb.pop_front());
            end else if (validBottom && qb.size() != 0) begin
                chk("bottom_hold", nodeIdxOut, qb[0]);
            end
        end
    end

    task automatic run(input vec_t v);
        node_desc_t d;
        int t = 0;
        while (!readyIn && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("readyIn_wait", readyIn, 1);
        d.featSel   = v.fs;
        d.threshold = v.thr;
        sampleIn      = v.samp;
        nodeIdxIn     = v.idx;
        validIdxIn    = 1'b1;
        validSampIn   = 1'b1;
        nodeData      = d;
        nodeDataValid = 1'b1;
        memRdy        = (v.stall == 0);
        readyBottom   = (v.bstall == 0);
        readyRight    = 1'b1;
        qb.push_back(v.child);
        qr.push_back(v.samp);
        @(posedge clk); #1;
        validIdxIn  = 1'b0;
        validSampIn = 1'b0;
        chk("fetch_memReq", memReq, 1);
        chk("fetch_memAddr", memAddr, v.idx);
        chk("fetch_readyIn", readyIn, 0);
        if (v.stall > 0) begin
            repeat (v.stall) begin
                @(posedge clk); #1;
                chk("stall_memReq", memReq, 1);
                chk("stall_valids", {validBottom, validRight}, 0);
                chk("stall_readyIn", readyIn, 0);
            end
            memRdy = 1'b1;
        end
        @(posedge clk); #1;
        memRdy        = 1'b0;
        nodeDataValid = 1'b0;
        chk("out_valids", {validBottom, validRight}, 2'b11);
        chk("out_memReq", memReq, 0);
        if (v.bstall > 0) begin
            repeat (v.bstall) begin
                @(posedge clk); #1;
                chk("bstall_validRight", validRight, 0);
                chk("bstall_validBottom", validBottom, 1);
                chk("bstall_readyIn", readyIn, 0);
            end
            readyBottom = 1'b1;
        end
        @(posedge clk); #1;
        chk("done_valids", {validBottom, validRight}, 0);
        chk("done_readyIn", readyIn, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{16'h0F3A, 4'd1,  4'd0,  4'd6,  4'd3,  0, 0};
        tbl[1] = '{16'h0F3A, 4'd3,  4'd1,  4'd6,  4'd6,  0, 0};
        tbl[2] = '{16'h0F3A, 4'd6,  4'd2,  4'd15, 4'd12, 0, 0};
        tbl[3] = '{16'h0F3A, 4'd9,  4'd3,  4'd0,  4'd2,  0, 0};
        tbl[4] = '{16'h0F3A, 4'd7,  4'd6,  4'd14, 4'd15, 0, 0};
        tbl[5] = '{16'hABCD, 4'd15, 4'd13, 4'd12, 4'd14, 0, 0};
        tbl[6] = '{16'hABCD, 4'd5,  4'd0,  4'd12, 4'd11, 0, 0};
        tbl[7] = '{16'h0F3A, 4'd1,  4'd0,  4'd6,  4'd3,  5, 0};
        tbl[8] = '{16'h0F3A, 4'd1,  4'd0,  4'd6,  4'd3,  0, 4};

        #12;
        chk("reset_readyIn", readyIn, 1);
        chk("reset_valids", {validBottom, validRight}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_readyIn", readyIn, 1);
        chk("post_reset_memReq", memReq, 0);
        chk("post_reset_nodeIdxOut", nodeIdxOut, 0);

        for (int i = 0; i < 9; i++) run(tbl[i]);

        sampleIn    = 16'h5555;
        nodeIdxIn   = 4'd2;
        validSampIn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("single_valid_readyIn", readyIn, 1);
            chk("single_valid_memReq", memReq, 0);
        end
        validIdxIn = 1'b1;
        memRdy     = 1'b0;
        @(posedge clk); #1;
        validIdxIn  = 1'b0;
        validSampIn = 1'b0;
        chk("abort_memReq", memReq, 1);
        #2 rst = 1'b0;
        #1;
        chk("abort_readyIn", readyIn, 1);
        chk("abort_memReq_rst", memReq, 0);
        chk("abort_memAddr", memAddr, 0);
        chk("abort_nodeIdxOut", nodeIdxOut, 0);
        chk("abort_sampleOut", sampleOut, 0);
        chk("abort_valids", {validBottom, validRight}, 0);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk("recover_readyIn", readyIn, 1);
        run(tbl[6]);

        chk("scoreboard_empty", qb.size() + qr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
